// File: rtl/hsv_core_alu_shift_add.sv
// hsv_core_alu_shift_add
// ALU execute stage: funnel shift, 33-bit add and compare bit, fed by the
// bitwise/setup stage and consumed by the writeback select stage.
//
// Default build is a two-stage pipeline. Stage 1 does the coarse shift
// (count[4:FINE_BITS]) and the add. Stage 2 does the fine shift
// (count[FINE_BITS-1:0]) and registers the outputs.
// Defining HSV_ALU_SHIFT_ADD_SINGLE_CYCLE_EN drops the stage 1 registers.
// The full shift and add then go straight into the output registers, for a
// latency of 1.
//
// Ports:
//   clk_core, rst_core       clock, asynchronous active-high reset
//   stall                    hold every pipeline register
//   flush_req                kill in-flight ops (wins over stall)
//   valid_i, in_alu_data     op valid and descriptor (descriptor passed through)
//   in_shift_lo/hi/count     funnel operands; result = ({hi,lo} >> count)[31:0]
//   in_adder_a/b             33-bit adder operands (b already negated/flipped)
//   valid_o, out_alu_data    result valid and aligned descriptor
//   out_shift_result         shift/bitwise result
//   out_adder_sum            (a + b) mod 2^33
//   out_compare              out_adder_sum[32] (slt/sltu)

package hsv_alu_pkg;
  typedef logic [15:0] alu_data_t;
endpackage

module hsv_core_alu_shift_add
  import hsv_alu_pkg::*;
#(
  parameter int FINE_BITS = 3
) (
  input  logic        clk_core,
  input  logic        rst_core,
  input  logic        stall,
  input  logic        flush_req,
  input  logic        valid_i,
  input  alu_data_t   in_alu_data,
  input  logic [31:0] in_shift_lo,
  input  logic [31:0] in_shift_hi,
  input  logic [4:0]  in_shift_count,
  input  logic [32:0] in_adder_a,
  input  logic [32:0] in_adder_b,
  output logic        valid_o,
  output alu_data_t   out_alu_data,
  output logic [31:0] out_shift_result,
  output logic [32:0] out_adder_sum,
  output logic        out_compare
);

  logic [63:0] funnel;
  logic [32:0] sum_comb;

  assign funnel   = {in_shift_hi, in_shift_lo};
  assign sum_comb = in_adder_a + in_adder_b;

  // Sources for the output register set
  logic        s2_valid;
  alu_data_t   s2_data;
  logic [31:0] s2_shift;
  logic [32:0] s2_sum;

`ifdef HSV_ALU_SHIFT_ADD_SINGLE_CYCLE_EN

  assign s2_valid = valid_i;
  assign s2_data  = in_alu_data;
  assign s2_shift = 32'(funnel >> in_shift_count);
  assign s2_sum   = sum_comb;

`else

  logic                 v1;
  alu_data_t            d1;
  logic [62:0]          f1;
  logic [FINE_BITS-1:0] c1;
  logic [32:0]          sum1;

  logic [4:0]  coarse_amt;
  logic [62:0] coarse_shift;

  // Total shift is at most 31, so 63 bits after the coarse step still hold
  // every bit that can reach the low 32 after the fine step.
  assign coarse_amt   = {in_shift_count[4:FINE_BITS], {FINE_BITS{1'b0}}};
  assign coarse_shift = 63'(funnel >> coarse_amt);

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      v1   <= 1'b0;
      d1   <= '0;
      f1   <= '0;
      c1   <= '0;
      sum1 <= '0;
    end else begin
      if (flush_req)
        v1 <= 1'b0;
      else if (!stall)
        v1 <= valid_i;
      if (!stall) begin
        d1   <= in_alu_data;
        f1   <= coarse_shift;
        c1   <= in_shift_count[FINE_BITS-1:0];
        sum1 <= sum_comb;
      end
    end
  end

  assign s2_valid = v1;
  assign s2_data  = d1;
  assign s2_shift = 32'(f1 >> c1);
  assign s2_sum   = sum1;

`endif

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      valid_o          <= 1'b0;
      out_alu_data     <= '0;
      out_shift_result <= '0;
      out_adder_sum    <= '0;
      out_compare      <= 1'b0;
    end else begin
      if (flush_req)
        valid_o <= 1'b0;
      else if (!stall)
        valid_o <= s2_valid;
      if (!stall) begin
        out_alu_data     <= s2_data;
        out_shift_result <= s2_shift;
        out_adder_sum    <= s2_sum;
        out_compare      <= s2_sum[32];
      end
    end
  end

endmodule

// File: tb/tb_hsv_core_alu_shift_add.sv
module tb_hsv_core_alu_shift_add;
  import hsv_alu_pkg::*;

`ifdef HSV_ALU_SHIFT_ADD_SINGLE_CYCLE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk_core = 1'b0;
  logic        rst_core;
  logic        stall;
  logic        flush_req;
  logic        valid_i;
  alu_data_t   in_alu_data;
  logic [31:0] in_shift_lo;
  logic [31:0] in_shift_hi;
  logic [4:0]  in_shift_count;
  logic [32:0] in_adder_a;
  logic [32:0] in_adder_b;
  logic        valid_o;
  alu_data_t   out_alu_data;
  logic [31:0] out_shift_result;
  logic [32:0] out_adder_sum;
  logic        out_compare;

  int n_cmp  = 0;
  int n_fail = 0;

  hsv_core_alu_shift_add dut (
    .clk_core        (clk_core),
    .rst_core        (rst_core),
    .stall           (stall),
    .flush_req       (flush_req),
    .valid_i         (valid_i),
    .in_alu_data     (in_alu_data),
    .in_shift_lo     (in_shift_lo),
    .in_shift_hi     (in_shift_hi),
    .in_shift_count  (in_shift_count),
    .in_adder_a      (in_adder_a),
    .in_adder_b      (in_adder_b),
    .valid_o         (valid_o),
    .out_alu_data    (out_alu_data),
    .out_shift_result(out_shift_result),
    .out_adder_sum   (out_adder_sum),
    .out_compare     (out_compare)
  );

  always #5 clk_core = ~clk_core;

  // Reference model: each accepted op waits LAT un-stalled edges, then shows up.
  typedef struct {
    alu_data_t   data;
    logic [31:0] shift;
    logic [32:0] sum;
    int          remain;
  } op_t;

  op_t pend[$];
  op_t m_op;
  logic m_valid = 1'b0;

  function automatic op_t make_op();
    op_t o;
    logic [63:0] fun;
    logic [33:0] s;
    fun     = {in_shift_hi, in_shift_lo} >> in_shift_count;
    s       = {1'b0, in_adder_a} + {1'b0, in_adder_b};
    o.data  = in_alu_data;
    o.shift = fun[31:0];
    o.sum   = s[32:0];
    o.remain = LAT;
    return o;
  endfunction

  // Advance one clock; inputs are sampled by the model exactly as the DUT sees them.
  task automatic tick();
    op_t n;
    n = make_op();
    @(posedge clk_core);
    if (rst_core || flush_req) begin
      pend.delete();
      m_valid = 1'b0;
    end else if (!stall) begin
      if (valid_i) pend.push_back(n);
      m_valid = 1'b0;
      foreach (pend[i]) pend[i].remain--;
      if (pend.size() > 0 && pend[0].remain == 0) begin
        m_op    = pend.pop_front();
        m_valid = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush_req = 0; valid_i = 0;
    in_alu_data = '0; in_shift_lo = '0; in_shift_hi = '0; in_shift_count = '0;
    in_adder_a = '0; in_adder_b = '0;
  endtask

  task automatic test_reset();
    rst_core = 1'b1;
    idle_inputs();
    valid_i = 1'b1;
    in_shift_lo = 32'h1234_5678; in_adder_a = 33'h1_0000_0001;
    tick(); tick();
    n_cmp++;
    if (valid_o !== 1'b0 || out_alu_data !== '0 || out_shift_result !== '0 ||
        out_adder_sum !== '0 || out_compare !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got v=%b d=%h sh=%h sum=%h cmp=%b want all 0",
               valid_o, out_alu_data, out_shift_result, out_adder_sum, out_compare);
    end
    idle_inputs();
    #2 rst_core = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    logic [31:0] t_hi [5] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFF};
    logic [31:0] t_lo [5] = '{32'h0, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0, 32'h8000_0000};
    logic [4:0]  t_cnt[5] = '{5'd31, 5'd4, 5'd0, 5'd0, 5'd31};
    logic [32:0] t_a  [5] = '{33'h0, 33'h0_0000_0003, 33'h1_FFFF_FFFF, 33'h0, 33'h0};
    logic [32:0] t_b  [5] = '{33'h0, 33'h1_FFFF_FFFB, 33'h0_0000_0001, 33'h0, 33'h0};
    logic [31:0] x_sh [5] = '{32'h0000_0002, 32'hF800_0000, 32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFFF};
    logic [32:0] x_sum[5] = '{33'h0, 33'h1_FFFF_FFFE, 33'h0, 33'h0, 33'h0};
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      valid_i = 1'b1; in_alu_data = alu_data_t'(16'hA000 + i);
      in_shift_hi = t_hi[i]; in_shift_lo = t_lo[i]; in_shift_count = t_cnt[i];
      in_adder_a = t_a[i]; in_adder_b = t_b[i];
      tick();
      idle_inputs();
      for (int k = 1; k < LAT; k++) tick();
      n_cmp++;
      if (valid_o !== 1'b1 || out_shift_result !== x_sh[i] || out_adder_sum !== x_sum[i] ||
          out_compare !== x_sum[i][32] || out_alu_data !== alu_data_t'(16'hA000 + i)) begin
        n_fail++;
        $display("FAIL directed_%0d got v=%b sh=%h sum=%h cmp=%b d=%h want v=1 sh=%h sum=%h cmp=%b d=%h",
                 i, valid_o, out_shift_result, out_adder_sum, out_compare, out_alu_data,
                 x_sh[i], x_sum[i], x_sum[i][32], 16'hA000 + i);
      end
    end
    tick();
  endtask

  task automatic test_stall();
    int edges;
    idle_inputs();
    valid_i = 1'b1; in_alu_data = 16'h5A5A;
    in_shift_hi = 32'h0; in_shift_lo = 32'h0000_00F0; in_shift_count = 5'd4;
    in_adder_a = 33'd7; in_adder_b = 33'd8;
    tick();
    edges = 1;
    idle_inputs();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (valid_o !== (LAT == 1)) begin
        n_fail++;
        $display("FAIL stall_hold_valid k=%0d got %b want %b", k, valid_o, LAT == 1);
      end
    end
    stall = 1'b0;
    while (!valid_o && edges < 8) begin
      tick();
      edges++;
    end
    n_cmp++;
    if (edges != LAT || out_shift_result !== 32'h0000_000F || out_adder_sum !== 33'd15 ||
        out_alu_data !== 16'h5A5A) begin
      n_fail++;
      $display("FAIL stall_latency got edges=%0d sh=%h sum=%h d=%h want edges=%0d sh=0000000f sum=15 d=5a5a",
               edges, out_shift_result, out_adder_sum, out_alu_data, LAT);
    end
    stall = 1'b1;
    tick(); tick();
    n_cmp++;
    if (valid_o !== 1'b1 || out_shift_result !== 32'h0000_000F || out_adder_sum !== 33'd15) begin
      n_fail++;
      $display("FAIL stall_frozen got v=%b sh=%h sum=%h want v=1 sh=0000000f sum=15",
               valid_o, out_shift_result, out_adder_sum);
    end
    idle_inputs();
    tick(); tick();
  endtask

  task automatic test_flush();
    idle_inputs();
    valid_i = 1'b1; in_alu_data = 16'h0001; in_adder_a = 33'd1;
    tick();
    in_alu_data = 16'h0002; in_adder_a = 33'd2;
    tick();
    idle_inputs();
    stall = 1'b1; flush_req = 1'b1;
    tick();
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_during_stall got valid_o=%b want 0", valid_o);
    end
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_no_emit k=%0d got valid_o=%b want 0", k, valid_o);
      end
    end
    valid_i = 1'b1; flush_req = 1'b1; in_alu_data = 16'h0003;
    tick();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (valid_o !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_with_valid k=%0d got valid_o=%b want 0", k, valid_o);
      end
    end
  endtask

  task automatic test_async_reset();
    int edges;
    idle_inputs();
    valid_i = 1'b1; in_alu_data = 16'h0BAD; in_adder_a = 33'd3;
    tick();
    tick();
    idle_inputs();
    #2 rst_core = 1'b1;
    pend.delete();
    m_valid = 1'b0;
    #1;
    n_cmp++;
    if (valid_o !== 1'b0 || out_adder_sum !== '0) begin
      n_fail++;
      $display("FAIL async_reset got valid_o=%b sum=%h want 0 0", valid_o, out_adder_sum);
    end
    #2 rst_core = 1'b0;
    tick();
    valid_i = 1'b1; in_alu_data = 16'h00C0; in_adder_a = 33'd20; in_adder_b = 33'd22;
    tick();
    edges = 1;
    idle_inputs();
    while (!valid_o && edges < 8) begin
      tick();
      edges++;
    end
    n_cmp++;
    if (edges != LAT || out_adder_sum !== 33'd42 || out_alu_data !== 16'h00C0) begin
      n_fail++;
      $display("FAIL post_reset_latency got edges=%0d sum=%0d d=%h want edges=%0d sum=42 d=00c0",
               edges, out_adder_sum, out_alu_data, LAT);
    end
    tick(); tick();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      valid_i     = ($urandom_range(99) < 70);
      stall       = ($urandom_range(99) < 20);
      flush_req   = ($urandom_range(99) < 5);
      in_alu_data = alu_data_t'($urandom);
      in_shift_lo = $urandom;
      in_shift_hi = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
      case ($urandom_range(3))
        0: in_shift_count = 5'd0;
        1: in_shift_count = 5'd31;
        default: in_shift_count = 5'($urandom);
      endcase
      in_adder_a = {1'($urandom), 32'($urandom)};
      in_adder_b = {1'($urandom), 32'($urandom)};
      tick();
      n_cmp++;
      if (valid_o !== m_valid) begin
        n_fail++;
        $display("FAIL rand_valid cyc=%0d got %b want %b", cyc, valid_o, m_valid);
      end
      if (m_valid) begin
        n_cmp++;
        if (out_shift_result !== m_op.shift || out_adder_sum !== m_op.sum ||
            out_compare !== m_op.sum[32] || out_alu_data !== m_op.data) begin
          n_fail++;
          $display("FAIL rand_data cyc=%0d got sh=%h sum=%h cmp=%b d=%h want sh=%h sum=%h cmp=%b d=%h",
                   cyc, out_shift_result, out_adder_sum, out_compare, out_alu_data,
                   m_op.shift, m_op.sum, m_op.sum[32], m_op.data);
        end
      end
      n_cmp++;
      if ($isunknown({out_shift_result, out_adder_sum, out_compare, out_alu_data})) begin
        n_fail++;
        $display("FAIL rand_no_x cyc=%0d got X on data outputs want known", cyc);
      end
    end
    idle_inputs();
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
